// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: 3-5 states per instruction plus MEM_WAIT dwell cycles
// in FETCH/MEMRD/MEMWR. Outputs decode from state, counter and OP; only BRANCH PCWrite follows Zero combinationally.
module multicycle_control #(
    parameter int OP_WIDTH    = 6,
    parameter int ALUOP_WIDTH = 3,
    parameter int MEM_WAIT    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_WIDTH-1:0]    OP,
    input  logic                   Zero,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             RegDst,
    output logic [1:0]             MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [1:0]             PCSource,
    output logic                   IllegalOp,
    output logic [3:0]             State
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC_R = 4'd6;
    localparam logic [3:0] EXEC_I = 4'd7;
    localparam logic [3:0] ALUWB  = 4'd8;
    localparam logic [3:0] BRANCH = 4'd9;
    localparam logic [3:0] JUMP   = 4'd10;
    localparam logic [3:0] LUIWB  = 4'd11;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'h00);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'h02);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(6'h03);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'h04);
    localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'h05);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'h08);
    localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(6'h0c);
    localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'h0d);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'h0f);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'h23);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'h2b);

    localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

    logic [3:0]    state;
    logic [3:0]    nextState;
    logic [CW-1:0] dwell;
    logic          dwellDone;
    logic          illegalReg;
    logic [2:0]    aluOp3;

    assign dwellDone = (dwell == WAIT_LAST);

    always_comb begin
        nextState = state;
        case (state)
            FETCH:  if (dwellDone) nextState = DECODE;
            DECODE: begin
                case (OP)
                    OP_LW, OP_SW:              nextState = MEMADR;
                    OP_R:                      nextState = EXEC_R;
                    OP_ADDI, OP_ORI, OP_ANDI:  nextState = EXEC_I;
                    OP_BEQ, OP_BNE:            nextState = BRANCH;
                    OP_J, OP_JAL:              nextState = JUMP;
                    OP_LUI:                    nextState = LUIWB;
                    default:                   nextState = FETCH;
                endcase
            end
            MEMADR: nextState = (OP == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (dwellDone) nextState = MEMWB;
            MEMWR:  if (dwellDone) nextState = FETCH;
            EXEC_R, EXEC_I: nextState = ALUWB;
            default: nextState = FETCH;
        endcase
    end

    // Only the dwell states ever loop on themselves, so any state change is an entry that restarts the counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            dwell      <= '0;
            illegalReg <= 1'b0;
        end else begin
            state <= nextState;
            dwell <= (nextState != state) ? '0 : dwell + CW'(1);
            if (state == DECODE && nextState == FETCH)
                illegalReg <= 1'b1;
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        aluOp3    = 3'b000;
        PCSource  = 2'b00;
        IllegalOp = 1'b0;
        State     = 4'd0;
        if (!reset) begin
            IllegalOp = illegalReg;
            State     = state;
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    aluOp3  = 3'b011;
                    IRWrite = dwellDone;
                    PCWrite = dwellDone;
                end
                DECODE: begin
                    ALUSrcB = 2'b10;
                    aluOp3  = 3'b011;
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    aluOp3  = 3'b011;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    aluOp3  = 3'b111;
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    case (OP)
                        OP_ADDI: begin ALUSrcB = 2'b10; aluOp3 = 3'b011; end
                        OP_ORI:  begin ALUSrcB = 2'b11; aluOp3 = 3'b001; end
                        OP_ANDI: begin ALUSrcB = 2'b11; aluOp3 = 3'b000; end
                        default: ;
                    endcase
                end
                ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = (OP == OP_R) ? 2'b01 : 2'b00;
                end
                BRANCH: begin
                    ALUSrcA  = 1'b1;
                    aluOp3   = 3'b100;
                    PCSource = 2'b01;
                    PCWrite  = (OP == OP_BNE) ? ~Zero : Zero;
                end
                JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                    if (OP == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                LUIWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b11;
                    aluOp3   = 3'b101;
                end
                default: ;
            endcase
        end
    end

    assign ALUOp = ALUOP_WIDTH'(aluOp3);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: two controller instances (MEM_WAIT=0 and MEM_WAIT=2) driven by directed per-cycle vectors.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw, iord, mr, mw, irw;
        logic [1:0] rd, m2r;
        logic       rw, sa;
        logic [1:0] sb;
        logic [2:0] aop;
        logic [1:0] pcs;
        logic       ill;
        logic [3:0] st;
    } ov_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, rst2 = 1'b1;
    logic [5:0] op0 = '0, op2 = '0;
    logic       zero0 = 1'b0, zero2 = 1'b0;

    logic pcw0, iord0, mr0, mw0, irw0, rw0, sa0, ill0;
    logic [1:0] rd0, m2r0, sb0, pcs0;
    logic [2:0] aop0;
    logic [3:0] st0;
    logic pcw2, iord2, mr2, mw2, irw2, rw2, sa2, ill2;
    logic [1:0] rd2, m2r2, sb2, pcs2;
    logic [2:0] aop2;
    logic [3:0] st2;

    multicycle_control #(.OP_WIDTH(6), .ALUOP_WIDTH(3), .MEM_WAIT(0)) dut0 (
        .clk(clk), .reset(rst0), .OP(op0), .Zero(zero0),
        .PCWrite(pcw0), .IorD(iord0), .MemRead(mr0), .MemWrite(mw0), .IRWrite(irw0),
        .RegDst(rd0), .MemtoReg(m2r0), .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0),
        .ALUOp(aop0), .PCSource(pcs0), .IllegalOp(ill0), .State(st0));

    multicycle_control #(.OP_WIDTH(6), .ALUOP_WIDTH(3), .MEM_WAIT(2)) dut2 (
        .clk(clk), .reset(rst2), .OP(op2), .Zero(zero2),
        .PCWrite(pcw2), .IorD(iord2), .MemRead(mr2), .MemWrite(mw2), .IRWrite(irw2),
        .RegDst(rd2), .MemtoReg(m2r2), .RegWrite(rw2), .ALUSrcA(sa2), .ALUSrcB(sb2),
        .ALUOp(aop2), .PCSource(pcs2), .IllegalOp(ill2), .State(st2));

    ov_t act0, act2;
    assign act0 = {pcw0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, sa0, sb0, aop0, pcs0, ill0, st0};
    assign act2 = {pcw2, iord2, mr2, mw2, irw2, rd2, m2r2, rw2, sa2, sb2, aop2, pcs2, ill2, st2};

    ov_t   expQ[$];
    logic  selQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    function automatic ov_t mk(input logic [3:0] st, input logic pcw, iord, mr, mw, irw,
                               input logic [1:0] rd, m2r, input logic rw, sa,
                               input logic [1:0] sb, input logic [2:0] aop, input logic [1:0] pcs);
        ov_t v;
        v = {pcw, iord, mr, mw, irw, rd, m2r, rw, sa, sb, aop, pcs, 1'b0, st};
        return v;
    endfunction

    // Expected per-state output vectors, written out field by field from the state table.
    ov_t Z, FM, FL, DEC, MA, MR, MWB, MW, ER, EI_ADDI, EI_ORI, EI_ANDI, WBR, WBI;
    ov_t BR_T, BR_N, JJ, JAL, LUI;
    initial begin
        //          st  pcw io mr mw ir rd    m2r   rw sa sb    aop     pcs
        Z       = '0;
        FM      = mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd1, 3'd3, 2'd0);
        FL      = mk(0, 1, 0, 1, 0, 1, 2'd0, 2'd0, 0, 0, 2'd1, 3'd3, 2'd0);
        DEC     = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd2, 3'd3, 2'd0);
        MA      = mk(2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'd3, 2'd0);
        MR      = mk(3, 0, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0);
        MWB     = mk(4, 0, 0, 0, 0, 0, 2'd0, 2'd1, 1, 0, 2'd0, 3'd0, 2'd0);
        MW      = mk(5, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd0);
        ER      = mk(6, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'd7, 2'd0);
        EI_ADDI = mk(7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd2, 3'd3, 2'd0);
        EI_ORI  = mk(7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd3, 3'd1, 2'd0);
        EI_ANDI = mk(7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd3, 3'd0, 2'd0);
        WBR     = mk(8, 0, 0, 0, 0, 0, 2'd1, 2'd0, 1, 0, 2'd0, 3'd0, 2'd0);
        WBI     = mk(8, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 2'd0, 3'd0, 2'd0);
        BR_T    = mk(9, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'd4, 2'd1);
        BR_N    = mk(9, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 2'd0, 3'd4, 2'd1);
        JJ      = mk(10, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2'd0, 3'd0, 2'd2);
        JAL     = mk(10, 1, 0, 0, 0, 0, 2'd2, 2'd2, 1, 0, 2'd0, 3'd0, 2'd2);
        LUI     = mk(11, 0, 0, 0, 0, 0, 2'd0, 2'd3, 1, 0, 2'd0, 3'd5, 2'd0);
    end

    // One call per clock: drive the selected instance's inputs just after the edge and
    // queue what that instance must show during this cycle.
    task automatic step(input logic sel, input logic rst, input logic [5:0] op, input logic z,
                        input ov_t v, input logic ill, input string nm);
        ov_t e;
        @(posedge clk);
        #1;
        if (sel) begin rst2 = rst; op2 = op; zero2 = z; end
        else     begin rst0 = rst; op0 = op; zero0 = z; end
        e = v;
        e.ill = ill;
        expQ.push_back(e);
        selQ.push_back(sel);
        nameQ.push_back(nm);
    endtask

    ov_t   mExp, mAct;
    logic  mSel;
    string mName;
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            mExp  = expQ.pop_front();
            mSel  = selQ.pop_front();
            mName = nameQ.pop_front();
            mAct  = mSel ? act2 : act0;
            checks++;
            if (mAct !== mExp) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", mName, mAct, mExp);
            end
        end
    end

    always @(negedge clk) begin
        if (rst0 === 1'b1) begin
            checks++;
            if (act0 !== '0) begin
                errors++;
                $display("FAIL reset_state dut0: outputs %h not all zero during reset", act0);
            end
        end
        if (rst2 === 1'b1) begin
            checks++;
            if (act2 !== '0) begin
                errors++;
                $display("FAIL reset_state dut2: outputs %h not all zero during reset", act2);
            end
        end
    end

    int fetchRun2 = 0;
    always @(negedge clk) begin
        if (rst2 !== 1'b0) begin
            fetchRun2 = 0;
        end else if (st2 == 4'd0) begin
            fetchRun2++;
            if (irw2 === 1'b1) begin
                checks++;
                if (fetchRun2 != 3) begin
                    errors++;
                    $display("FAIL expired_wait dut2: IRWrite in fetch cycle %0d, expected 3", fetchRun2);
                end
                fetchRun2 = 0;
            end
        end else begin
            fetchRun2 = 0;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(0, 1, 6'h00, 0, Z, 0, "reset_hold");
        step(0, 0, 6'h00, 0, FL,  0, "r_fetch");
        step(0, 0, 6'h00, 0, DEC, 0, "r_decode");
        step(0, 0, 6'h00, 0, ER,  0, "r_exec");
        step(0, 0, 6'h00, 0, WBR, 0, "r_wb");

        step(0, 0, 6'h04, 0, FL,   0, "beq_fetch");
        step(0, 0, 6'h04, 0, DEC,  0, "beq_decode");
        step(0, 0, 6'h04, 1, BR_T, 0, "beq_zero1");
        step(0, 0, 6'h04, 0, FL,   0, "beq_fetch");
        step(0, 0, 6'h04, 0, DEC,  0, "beq_decode");
        step(0, 0, 6'h04, 0, BR_N, 0, "beq_zero0");
        step(0, 0, 6'h05, 0, FL,   0, "bne_fetch");
        step(0, 0, 6'h05, 0, DEC,  0, "bne_decode");
        step(0, 0, 6'h05, 1, BR_N, 0, "bne_zero1");
        step(0, 0, 6'h05, 0, FL,   0, "bne_fetch");
        step(0, 0, 6'h05, 0, DEC,  0, "bne_decode");
        step(0, 0, 6'h05, 0, BR_T, 0, "bne_zero0");

        step(0, 0, 6'h03, 0, FL,  0, "jal_fetch");
        step(0, 0, 6'h03, 0, DEC, 0, "jal_decode");
        step(0, 0, 6'h03, 0, JAL, 0, "jal_jump");
        step(0, 0, 6'h02, 0, FL,  0, "j_fetch");
        step(0, 0, 6'h02, 0, DEC, 0, "j_decode");
        step(0, 0, 6'h02, 0, JJ,  0, "j_jump");
        step(0, 0, 6'h0f, 0, FL,  0, "lui_fetch");
        step(0, 0, 6'h0f, 0, DEC, 0, "lui_decode");
        step(0, 0, 6'h0f, 0, LUI, 0, "lui_wb");
        step(0, 0, 6'h0d, 0, FL,     0, "ori_fetch");
        step(0, 0, 6'h0d, 0, DEC,    0, "ori_decode");
        step(0, 0, 6'h0d, 0, EI_ORI, 0, "ori_exec");
        step(0, 0, 6'h0d, 0, WBI,    0, "ori_wb");
        step(0, 0, 6'h2b, 0, FL,  0, "sw_fetch");
        step(0, 0, 6'h2b, 0, DEC, 0, "sw_decode");
        step(0, 0, 6'h2b, 0, MA,  0, "sw_memadr");
        step(0, 0, 6'h2b, 0, MW,  0, "sw_memwr");

        step(0, 0, 6'h3f, 0, FL,  0, "ill_fetch");
        step(0, 0, 6'h3f, 0, DEC, 0, "ill_decode");
        step(0, 0, 6'h08, 0, FL,      1, "ill_sticky_fetch");
        step(0, 0, 6'h08, 0, DEC,     1, "addi_decode");
        step(0, 0, 6'h08, 0, EI_ADDI, 1, "addi_exec");
        step(0, 0, 6'h08, 0, WBI,     1, "addi_wb");
        step(0, 0, 6'h0c, 0, FL,      1, "andi_fetch");
        step(0, 0, 6'h0c, 0, DEC,     1, "andi_decode");
        step(0, 0, 6'h0c, 0, EI_ANDI, 1, "andi_exec");
        step(0, 0, 6'h0c, 0, WBI,     1, "andi_wb");

        step(0, 0, 6'h23, 0, FL,  1, "lwrst_fetch");
        step(0, 0, 6'h23, 0, DEC, 1, "lwrst_decode");
        step(0, 0, 6'h23, 0, MA,  1, "lwrst_memadr");
        step(0, 1, 6'h23, 0, Z,   0, "lwrst_abort");
        step(0, 0, 6'h23, 0, FL,  0, "lwrst_restart");
        step(0, 0, 6'h23, 0, DEC, 0, "lw0_decode");
        step(0, 0, 6'h23, 0, MA,  0, "lw0_memadr");
        step(0, 0, 6'h23, 0, MR,  0, "lw0_memrd");
        step(0, 0, 6'h23, 0, MWB, 0, "lw0_memwb");

        // MEM_WAIT=2: every dwell state spans three cycles.
        step(1, 1, 6'h23, 0, Z,   0, "w2_reset");
        step(1, 0, 6'h23, 0, FM,  0, "lw2_fetch0");
        step(1, 0, 6'h23, 0, FM,  0, "lw2_fetch1");
        step(1, 0, 6'h23, 0, FL,  0, "lw2_fetch2");
        step(1, 0, 6'h23, 0, DEC, 0, "lw2_decode");
        step(1, 0, 6'h23, 0, MA,  0, "lw2_memadr");
        for (int i = 0; i < 3; i++) step(1, 0, 6'h23, 0, MR, 0, "lw2_memrd");
        step(1, 0, 6'h23, 0, MWB, 0, "lw2_memwb");
        step(1, 0, 6'h2b, 0, FM,  0, "sw2_fetch0");
        step(1, 0, 6'h2b, 0, FM,  0, "sw2_fetch1");
        step(1, 0, 6'h2b, 0, FL,  0, "sw2_fetch2");
        step(1, 0, 6'h2b, 0, DEC, 0, "sw2_decode");
        step(1, 0, 6'h2b, 0, MA,  0, "sw2_memadr");
        for (int i = 0; i < 3; i++) step(1, 0, 6'h2b, 0, MW, 0, "sw2_memwr");
        step(1, 0, 6'h2b, 0, FM,  0, "sw2_next_fetch");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
